// File: rtl/sr_cmd_sequencer.sv
// sr_cmd_sequencer: set/clear command sequencer driving an SR flip-flop's S and R inputs with a hold time and a dead-time gap; define SR_SEQ_VERIFY_EN to add the Q feedback check (q_i, err_o)
module sr_cmd_sequencer #(
  parameter int HOLD_CYCLES = 1,
  parameter int GAP_CYCLES  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_valid_i,
  input  logic cmd_op_i,
  output logic cmd_ready_o,
  output logic s_o,
  output logic r_o,
  output logic busy_o,
  output logic done_o,
`ifdef SR_SEQ_VERIFY_EN
  output logic q_exp_o,
  input  logic q_i,
  output logic err_o
`else
  output logic q_exp_o
`endif
);
  localparam int MX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic op_q, op_d, s_q, s_d, r_q, r_d, busy_q, busy_d, done_q, done_d, qexp_q, qexp_d;
  assign cmd_ready_o = state_q == IDLE;
  assign s_o         = s_q;
  assign r_o         = r_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign q_exp_o     = qexp_q;
  // next state; S/R/Busy are decoded from the next state so they leave a flop
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    qexp_d  = qexp_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (cmd_valid_i) begin
        op_d    = cmd_op_i;
        cnt_d   = CW'(HOLD_CYCLES - 1);
        state_d = DRIVE;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end else if (state_q == DRIVE) begin
      qexp_d  = op_q;
      state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
      done_d  = GAP_CYCLES == 0;
      cnt_d   = (GAP_CYCLES == 0) ? '0 : CW'(GAP_CYCLES - 1);
    end else begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
    s_d    = (state_d == DRIVE) &  op_d;
    r_d    = (state_d == DRIVE) & ~op_d;
    busy_d = state_d != IDLE;
  end
  // state and registered outputs; reset clears S/R immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      qexp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      s_q     <= s_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      qexp_q  <= qexp_d;
    end
  end
`ifdef SR_SEQ_VERIFY_EN
  logic err_q;
  assign err_o = err_q;
  // compare real Q against expectation at the end of each Done cycle; sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (done_q) err_q <= err_q | (q_i != qexp_q);
  end
`endif
endmodule
